// File: rtl/max_reduce_pkg.sv
// Shared types for the max-reduction stream: the tree node record, the
// pipeline depth derived from the lane count, and the signed minimum.
package max_reduce_pkg;

    localparam int N_DEF      = 8;
    localparam int DATA_W_DEF = 16;
    localparam int STAGES     = $clog2(N_DEF);
    localparam int LANE_W     = (STAGES > 0) ? STAGES : 1;

    typedef struct packed {
        logic                         any;
        logic signed [DATA_W_DEF-1:0] value;
        logic [LANE_W-1:0]            lane;
    } node_t;

    function automatic logic signed [DATA_W_DEF-1:0] min_val();
        return {1'b1, {(DATA_W_DEF-1){1'b0}}};
    endfunction

    function automatic node_t empty_node();
        return '{any: 1'b0, value: min_val(), lane: '0};
    endfunction

endpackage

// File: rtl/max_reduce_node.sv
// One registered comparator of the reduction tree. The left input always
// carries the lower lane numbers, so it wins value ties.
module max_reduce_node
    import max_reduce_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  node_t left_i,
    input  node_t right_i,
    output node_t node_o
);

    node_t node_d;
    node_t node_q;

    always_comb begin
        node_d = empty_node();
        if (left_i.any && (!right_i.any ||
                           $signed(left_i.value) >= $signed(right_i.value))) begin
            node_d = left_i;
        end else if (right_i.any) begin
            node_d = right_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q <= empty_node();
        end else if (en) begin
            node_q <= node_d;
        end
    end

    assign node_o = node_q;

endmodule

// File: rtl/max_reduce_stream.sv
// Pipelined N-lane signed max/argmax tree with lane masks, aligned data
// bypass and a per-row running maximum over multi-beat rows.
module max_reduce_stream
    import max_reduce_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = 64,
    parameter int IDX_W     = $clog2(N * MAX_BEATS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [N-1:0]               lane_mask,
    input  logic [N*DATA_W-1:0]        in_flat,
    output logic                       beat_valid_out,
    output logic                       beat_last_out,
    output logic                       beat_any,
    output logic signed [DATA_W-1:0]   beat_max,
    output logic [$clog2(N)-1:0]       beat_lane,
    output logic [N-1:0]               bypass_mask_out,
    output logic [N*DATA_W-1:0]        bypass_out,
    output logic                       row_valid_out,
    output logic                       row_any,
    output logic signed [DATA_W-1:0]   row_max,
    output logic [IDX_W-1:0]           row_idx,
    output logic                       row_ovf
);

    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
    localparam logic signed [DATA_W-1:0] MIN_V = min_val();

    // ---- p0: leaves, lane qualified by both beat valid and lane mask
    node_t leaf_p0 [N];
    node_t node_pn [1:N-1];

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign leaf_p0[i] = '{any:   in_valid & lane_mask[i],
                              value: in_flat[i*DATA_W +: DATA_W],
                              lane:  LANE_W'(i)};
    end

    // ---- p1..pSTAGES: heap-ordered tree, node k has children 2k and 2k+1
    for (genvar k = 1; k < N; k++) begin : g_node
        node_t l_in;
        node_t r_in;
        if (2 * k >= N) begin : g_from_leaf
            assign l_in = leaf_p0[2*k - N];
            assign r_in = leaf_p0[2*k + 1 - N];
        end else begin : g_from_node
            assign l_in = node_pn[2*k];
            assign r_in = node_pn[2*k + 1];
        end
        max_reduce_node u_node (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .left_i  (l_in),
            .right_i (r_in),
            .node_o  (node_pn[k])
        );
    end

    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   last_q;
    logic [N-1:0]        mask_q [STAGES];
    logic [N*DATA_W-1:0] data_q [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                mask_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else if (en) begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_valid & in_last;
            mask_q[0] <= lane_mask;
            data_q[0] <= in_flat;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                last_q[s] <= last_q[s-1];
                mask_q[s] <= mask_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign beat_valid_out  = vld_q[STAGES-1];
    assign beat_last_out   = last_q[STAGES-1];
    assign bypass_mask_out = mask_q[STAGES-1];
    assign bypass_out      = data_q[STAGES-1];
    assign beat_any        = node_pn[1].any;
    assign beat_max        = node_pn[1].value;
    assign beat_lane       = node_pn[1].lane;

    // ---- row accumulator, one cycle behind the tree root
    logic                     acc_any_q, acc_any_d;
    logic signed [DATA_W-1:0] acc_max_q, acc_max_d;
    logic [IDX_W-1:0]         acc_idx_q, acc_idx_d;
    logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     row_valid_q, row_valid_d;
    logic                     row_any_q, row_any_d;
    logic signed [DATA_W-1:0] row_max_q, row_max_d;
    logic [IDX_W-1:0]         row_idx_q, row_idx_d;
    logic                     row_ovf_q, row_ovf_d;

    logic                     take;
    logic                     mrg_any;
    logic signed [DATA_W-1:0] mrg_max;
    logic [IDX_W-1:0]         mrg_idx;
    logic [IDX_W-1:0]         cand_idx;

    assign cand_idx = IDX_W'({beat_cnt_q, beat_lane});

    always_comb begin
        take    = beat_any & (~acc_any_q | (beat_max > acc_max_q));
        mrg_any = acc_any_q | beat_any;
        mrg_max = take ? beat_max : acc_max_q;
        mrg_idx = take ? cand_idx : acc_idx_q;

        acc_any_d   = acc_any_q;
        acc_max_d   = acc_max_q;
        acc_idx_d   = acc_idx_q;
        beat_cnt_d  = beat_cnt_q;
        ovf_d       = ovf_q;
        row_valid_d = 1'b0;
        row_any_d   = row_any_q;
        row_max_d   = row_max_q;
        row_idx_d   = row_idx_q;
        row_ovf_d   = row_ovf_q;

        if (beat_valid_out) begin
            if (beat_last_out) begin
                // Close the row and restart the accumulator in the same cycle.
                row_valid_d = 1'b1;
                row_any_d   = mrg_any;
                row_max_d   = mrg_any ? mrg_max : MIN_V;
                row_idx_d   = mrg_any ? mrg_idx : '0;
                row_ovf_d   = ovf_q;
                acc_any_d   = 1'b0;
                acc_max_d   = '0;
                acc_idx_d   = '0;
                beat_cnt_d  = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_any_d = mrg_any;
                acc_max_d = mrg_max;
                acc_idx_d = mrg_idx;
                if (beat_cnt_q == LAST_BEAT) begin
                    ovf_d = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_any_q   <= 1'b0;
            acc_max_q   <= '0;
            acc_idx_q   <= '0;
            beat_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            row_valid_q <= 1'b0;
            row_any_q   <= 1'b0;
            row_max_q   <= MIN_V;
            row_idx_q   <= '0;
            row_ovf_q   <= 1'b0;
        end else if (en) begin
            acc_any_q   <= acc_any_d;
            acc_max_q   <= acc_max_d;
            acc_idx_q   <= acc_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            ovf_q       <= ovf_d;
            row_valid_q <= row_valid_d;
            row_any_q   <= row_any_d;
            row_max_q   <= row_max_d;
            row_idx_q   <= row_idx_d;
            row_ovf_q   <= row_ovf_d;
        end
    end

    assign row_valid_out = row_valid_q;
    assign row_any       = row_any_q;
    assign row_max       = row_max_q;
    assign row_idx       = row_idx_q;
    assign row_ovf       = row_ovf_q;

endmodule

// File: tb/tb_max_reduce_stream.sv
// Directed bench for max_reduce_stream (N=8, DATA_W=16, MAX_BEATS=4).
module tb_max_reduce_stream;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [7:0]   lane_mask = '0;
    logic [127:0] in_flat = '0;
    logic         beat_valid_out, beat_last_out, beat_any;
    logic [15:0]  beat_max;
    logic [2:0]   beat_lane;
    logic [7:0]   bypass_mask_out;
    logic [127:0] bypass_out;
    logic         row_valid_out, row_any, row_ovf;
    logic [15:0]  row_max;
    logic [4:0]   row_idx;

    int total = 0;
    int bad = 0;

    max_reduce_stream #(.N(8), .DATA_W(16), .MAX_BEATS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .lane_mask       (lane_mask),
        .in_flat         (in_flat),
        .beat_valid_out  (beat_valid_out),
        .beat_last_out   (beat_last_out),
        .beat_any        (beat_any),
        .beat_max        (beat_max),
        .beat_lane       (beat_lane),
        .bypass_mask_out (bypass_mask_out),
        .bypass_out      (bypass_out),
        .row_valid_out   (row_valid_out),
        .row_any         (row_any),
        .row_max         (row_max),
        .row_idx         (row_idx),
        .row_ovf         (row_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
        logic [127:0] r;
        r = {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [127:0] d, input logic [7:0] m, input logic last);
        in_valid  = 1'b1;
        in_flat   = d;
        lane_mask = m;
        in_last   = last;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        lane_mask = '0;
        in_flat   = '0;
    endtask

    task automatic chk_beat(input string tag, input logic vld, input logic any,
                            input logic [15:0] mx, input logic [2:0] ln);
        chk({tag, "_vld"}, beat_valid_out, vld);
        chk({tag, "_any"}, beat_any, any);
        chk({tag, "_max"}, beat_max, mx);
        chk({tag, "_lane"}, beat_lane, ln);
    endtask

    task automatic chk_row(input string tag, input logic any, input logic [15:0] mx,
                           input logic [4:0] idx, input logic ovf);
        chk({tag, "_vld"}, row_valid_out, 1'b1);
        chk({tag, "_any"}, row_any, any);
        chk({tag, "_max"}, row_max, mx);
        chk({tag, "_idx"}, row_idx, idx);
        chk({tag, "_ovf"}, row_ovf, ovf);
    endtask

    initial begin
        logic [127:0] d1;
        logic         seen;
        d1 = pk(3, -5, 100, 7, 100, 0, -1, 2);

        // reset state
        repeat (3) step();
        chk("rst_beat_max", beat_max, 16'h8000);
        chk("rst_row_max", row_max, 16'h8000);
        chk("rst_beat_vld", beat_valid_out, 1'b0);
        chk("rst_row_vld", row_valid_out, 1'b0);
        chk("rst_row_idx", row_idx, 5'd0);
        chk("rst_bypass", bypass_out, 128'd0);
        rst = 1'b0;
        step();

        // 1: full mask, tie between lanes 2 and 4
        drv(d1, 8'hFF, 1'b1); step(); idle(); step(); step();
        chk_beat("t1_beat", 1'b1, 1'b1, 16'd100, 3'd2);
        chk("t1_last", beat_last_out, 1'b1);
        chk("t1_bypass", bypass_out, d1);
        chk("t1_bmask", bypass_mask_out, 8'hFF);
        step();
        chk_row("t1_row", 1'b1, 16'd100, 5'd2, 1'b0);
        step();
        chk("t1_pulse_end", row_valid_out, 1'b0);
        chk("t1_row_hold", row_max, 16'd100);

        // 2: lane 2 masked off
        drv(d1, 8'hFB, 1'b1); step(); idle(); step(); step();
        chk_beat("t2_beat", 1'b1, 1'b1, 16'd100, 3'd4);
        chk("t2_bmask", bypass_mask_out, 8'hFB);
        step();
        chk_row("t2_row", 1'b1, 16'd100, 5'd4, 1'b0);

        // 3: three-beat row followed back-to-back by a two-beat row
        idle(); step();
        drv(pk(0, 40, -3, 5, 10, 1, 2, 39), 8'hFF, 1'b0); step();
        drv(pk(1, 2, 3, 4, 5, 90, 6, 7), 8'hFF, 1'b0); step();
        drv(pk(90, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 1'b1); step();
        chk_beat("t3_b0", 1'b1, 1'b1, 16'd40, 3'd1);
        drv(pk(-7, -2, -9, -4, -1, -3, -8, -6), 8'hFF, 1'b0); step();
        chk_beat("t3_b1", 1'b1, 1'b1, 16'd90, 3'd5);
        drv(pk(-5, -5, -5, -5, -5, -5, -5, -1), 8'hFF, 1'b1); step();
        chk_beat("t3_b2", 1'b1, 1'b1, 16'd90, 3'd0);
        chk("t3_b2_last", beat_last_out, 1'b1);
        idle(); step();
        chk_row("t3_row0", 1'b1, 16'd90, 5'd13, 1'b0);
        step();
        chk("t3_no_dup", row_valid_out, 1'b0);
        chk_beat("t3_r1b1", 1'b1, 1'b1, 16'hFFFF, 3'd7);
        step();
        chk_row("t3_row1", 1'b1, 16'hFFFF, 5'd4, 1'b0);

        // 4: empty row, then a row whose only valid lane holds the minimum
        idle(); step();
        drv(pk(500, 1, 2, 3, 4, 5, 6, 7), 8'h00, 1'b0); step();
        drv(pk(600, 1, 2, 3, 4, 5, 6, 7), 8'h00, 1'b1); step();
        drv(pk(-1, -2, -3, -32768, -4, -5, -6, -7), 8'h08, 1'b1); step();
        chk_beat("t4_empty", 1'b1, 1'b0, 16'h8000, 3'd0);
        idle(); step(); step();
        chk_row("t4_row0", 1'b0, 16'h8000, 5'd0, 1'b0);
        step();
        chk_row("t4_row1", 1'b1, 16'h8000, 5'd3, 1'b0);

        // 5: bubble mid-row and a 5-cycle stall with the row still open
        idle(); step();
        drv(pk(1, 2, 3, 4, 5, 6, 50, 7), 8'hFF, 1'b0); step();
        idle(); step();
        drv(pk(0, 60, -60, 0, 0, 0, 0, 0), 8'hFF, 1'b1); step();
        chk_beat("t5_s0", 1'b1, 1'b1, 16'd50, 3'd6);
        idle();
        en = 1'b0;
        repeat (5) step();
        chk_beat("t5_frozen", 1'b1, 1'b1, 16'd50, 3'd6);
        chk("t5_frozen_row", row_valid_out, 1'b0);
        en = 1'b1;
        step();
        chk("t5_bubble", beat_valid_out, 1'b0);
        step();
        chk_beat("t5_s1", 1'b1, 1'b1, 16'd60, 3'd1);
        step();
        chk_row("t5_row", 1'b1, 16'd60, 5'd9, 1'b0);
        en = 1'b0; step();
        chk("t5_pulse_hold", row_valid_out, 1'b1);
        en = 1'b1; step();
        chk("t5_pulse_end", row_valid_out, 1'b0);

        // 6a: exactly MAX_BEATS beats does not overflow
        for (int k = 0; k < 4; k++) begin
            drv(pk(0, 0, 10*k + 10, 0, 0, 0, 0, 0), 8'hFF, k == 3);
            step();
        end
        idle(); repeat (3) step();
        chk_row("t6_row4", 1'b1, 16'd40, 5'd26, 1'b0);

        // 6b: six beats overflow, index saturates at the last counted beat
        step();
        for (int k = 0; k < 6; k++) begin
            drv(pk(0, 0, 10*k + 10, 0, 0, 0, 0, 0), 8'hFF, k == 5);
            step();
        end
        idle(); repeat (3) step();
        chk_row("t6_row6", 1'b1, 16'd60, 5'd26, 1'b1);

        // 6c: reset with a closing beat in flight
        step();
        drv(pk(9, 9, 9, 9, 9, 9, 9, 9), 8'hFF, 1'b0); step();
        drv(pk(8, 8, 8, 8, 8, 8, 8, 8), 8'hFF, 1'b0); step();
        drv(pk(7, 7, 7, 7, 7, 7, 7, 7), 8'hFF, 1'b1); step();
        idle();
        rst = 1'b1;
        #1;
        chk("t6_rst_beat_vld", beat_valid_out, 1'b0);
        chk("t6_rst_beat_max", beat_max, 16'h8000);
        chk("t6_rst_row_max", row_max, 16'h8000);
        chk("t6_rst_row_ovf", row_ovf, 1'b0);
        chk("t6_rst_row_idx", row_idx, 5'd0);
        chk("t6_rst_bmask", bypass_mask_out, 8'h00);
        step(); step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (row_valid_out) seen = 1'b1;
        end
        chk("t6_no_pulse", seen, 1'b0);
        drv(pk(-3, 0, 1, 2, 3, 4, 1, 5), 8'hFF, 1'b1); step();
        idle(); repeat (3) step();
        chk_row("t6_clean", 1'b1, 16'd5, 5'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
